// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw switch level in, debounced level and rise strobe out
interface debounce_sync_if;
    logic sw;
    logic db_level;
    logic db_tick;
    modport master (output sw, input db_level, input db_tick);
    modport slave (input sw, output db_level, output db_tick);
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes and debounces a bouncing switch into a clean level plus rise strobe
module debounce_sync #(
    parameter int CNT_W      = 4,
    parameter int STABLE_CNT = 10
) (
    input logic           clk,
    input logic           reset,
    debounce_sync_if.slave bus
);
    localparam logic [1:0] ZERO  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] ONE   = 2'd2;
    localparam logic [1:0] WAIT0 = 2'd3;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STABLE_CNT - 1);
    logic s1, s2;
    logic [1:0] state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic level_nxt, tick_nxt;
    // two-flop synchronizer; the FSM only ever looks at s2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.sw;
            s2 <= s1;
        end
    end
    // stability FSM: a level change is accepted only after an unbroken run of s2
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;
        case (state)
            ZERO: begin
                if (s2) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = RELOAD;
                end
            end
            WAIT1: begin
                if (!s2) state_nxt = ZERO;
                else if (cnt == '0) begin
                    state_nxt = ONE;
                    tick_nxt  = 1'b1;
                end else cnt_nxt = cnt - 1'b1;
            end
            ONE: begin
                if (!s2) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = RELOAD;
                end
            end
            WAIT0: begin
                if (s2) state_nxt = ONE;
                else if (cnt == '0) state_nxt = ZERO;
                else cnt_nxt = cnt - 1'b1;
            end
            default: state_nxt = ZERO;
        endcase
        level_nxt = (state_nxt == ONE) || (state_nxt == WAIT0);
    end
    // state, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ZERO;
            cnt          <= '0;
            bus.db_level <= 1'b0;
            bus.db_tick  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bus.db_level <= level_nxt;
            bus.db_tick  <= tick_nxt;
        end
    end
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: scoreboard bench for default and STABLE_CNT=1 debouncers
module tb_debounce_sync;
    logic clk = 1'b0;
    logic rst_n;
    logic sw = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;
    int n_stable [2] = '{10, 1};
    logic m_s1, m_s2;
    logic m_lvl [2];
    logic m_tick [2];
    int m_run [2];
    logic [3:0] sb [$];
    int tick0 = 0, tick1 = 0;
    int last_rise0 = -1, last_fall0 = -1, last_rise1 = -1;
    logic prev0 = 1'b0, prev1 = 1'b0;
    int mark, t1_before;

    debounce_sync_if bus0 ();
    debounce_sync_if bus1 ();
    assign bus0.sw = sw;
    assign bus1.sw = sw;

    debounce_sync dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
    debounce_sync #(.CNT_W(1), .STABLE_CNT(1)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        edge_no = 0;
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 1'b0;
            m_tick[i] = 1'b0;
            m_run[i] = 0;
        end
    endtask

    // run-length model: level flips once s2 has disagreed for STABLE_CNT+1 samples in a row
    task automatic model_update(input logic v);
        for (int i = 0; i < 2; i++) begin
            m_run[i] = (m_s2 != m_lvl[i]) ? m_run[i] + 1 : 0;
            m_tick[i] = 1'b0;
            if (m_run[i] == n_stable[i] + 1) begin
                m_lvl[i] = m_s2;
                m_tick[i] = m_s2;
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = v;
    endtask

    task automatic step(input logic v);
        sw = v;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            edge_no++;
            model_update(v);
        end
        sb.push_back({m_lvl[0], m_tick[0], m_lvl[1], m_tick[1]});
        @(negedge clk);
    endtask

    task automatic steps(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("lvl0", bus0.db_level, e[3]);
                chk("tick0", bus0.db_tick, e[2]);
                chk("lvl1", bus1.db_level, e[1]);
                chk("tick1", bus1.db_tick, e[0]);
                if (bus0.db_tick) tick0++;
                if (bus1.db_tick) tick1++;
                if (bus0.db_level && !prev0) last_rise0 = edge_no;
                if (!bus0.db_level && prev0) last_fall0 = edge_no;
                if (bus1.db_level && !prev1) last_rise1 = edge_no;
                prev0 = bus0.db_level;
                prev1 = bus1.db_level;
            end
        end
    end

    initial begin
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("rst_lvl", bus0.db_level, 0);
        chk("rst_tick", bus0.db_tick, 0);
        @(negedge clk);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        rst_n = 1'b1;
        steps(1'b0, 4);
        step(1'b1);
        steps(1'b1, 14);
        chk("rise_edge", last_rise0, 17);
        chk("rise_ticks", tick0, 1);
        steps(1'b0, 4);
        step(1'b1);
        step(1'b0);
        mark = edge_no;
        steps(1'b0, 14);
        chk("fall_edge", last_fall0, mark + 12);
        chk("fall_ticks", tick0, 1);
        steps(1'b0, 2);
        steps(1'b1, 3);
        step(1'b0);
        step(1'b1);
        mark = edge_no;
        steps(1'b1, 14);
        chk("bounce_rise_edge", last_rise0, mark + 12);
        chk("bounce_rise_ticks", tick0, 2);
        steps(1'b0, 5);
        chk("pre_rst_lvl", bus0.db_level, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_lvl", bus0.db_level, 0);
        chk("async_tick", bus0.db_tick, 0);
        model_reset();
        @(negedge clk);
        steps(1'b0, 3);
        rst_n = 1'b1;
        steps(1'b0, 15);
        chk("post_rst_lvl", bus0.db_level, 0);
        chk("post_rst_ticks", tick0, 2);
        t1_before = tick1;
        step(1'b1);
        steps(1'b0, 4);
        chk("glitch1_lvl", bus1.db_level, 0);
        chk("glitch1_ticks", tick1 - t1_before, 0);
        step(1'b1);
        mark = edge_no;
        steps(1'b1, 2);
        steps(1'b0, 6);
        chk("corner_rise_edge", last_rise1, mark + 3);
        chk("corner_ticks", tick1 - t1_before, 1);
        chk("corner_lvl0", bus0.db_level, 0);
        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/debounce_sync.md
# debounce_sync

Cleans a raw, asynchronous, bouncing switch/pushbutton level for the sequence-detector path. A two-flop synchronizer is followed by a four-state stability FSM with a reload counter. The block drives a glitch-free registered level `db_level` and a one-cycle rising-edge strobe `db_tick`. `db_level` feeds the downstream 1s-reduction Mealy stage's `in`; `db_tick` is available to event counters.

## Interface
- `CNT_W`, 4, width of the stability counter; must satisfy 2^CNT_W >= STABLE_CNT.
- `STABLE_CNT`, 10, consecutive synchronized-stable cycles required to accept a level change; legal range 1 .. 2^CNT_W.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- `sw`  input  1  raw asynchronous switch level; may bounce.
- `db_level`  output  1  registered debounced level.
- `db_tick`  output  1  registered strobe; high exactly one cycle per accepted 0->1 change.

## Operation
- Synchronizer: `s1 <= sw`, `s2 <= s1`. The FSM sees only `s2`.
- Counter `cnt`, CNT_W bits, unsigned.
  - Loads STABLE_CNT-1 on entry to either wait state.
  - Decrements by 1 per cycle while in a wait state with `s2` unchanged.
  - Never wraps below 0.
- States (encoding free): ZERO, WAIT1, ONE, WAIT0. Default/illegal encodings go to ZERO.
- ZERO (`db_level`=0):
  - `s2`=1 -> WAIT1, load `cnt`.
  - Otherwise stay.
- WAIT1 (`db_level`=0):
  - `s2`=0 -> ZERO (bounce rejected; no output change).
  - `s2`=1 and `cnt`==0 -> ONE; `db_level` <= 1 and `db_tick` <= 1 on the same edge.
  - `s2`=1 and `cnt`!=0 -> `cnt` <= `cnt`-1.
- ONE (`db_level`=1):
  - `s2`=0 -> WAIT0, load `cnt`.
  - Otherwise stay.
- WAIT0 (`db_level`=1):
  - `s2`=1 -> ONE (bounce rejected).
  - `s2`=0 and `cnt`==0 -> ZERO; `db_level` <= 0. No strobe on falling changes.
  - `s2`=0 and `cnt`!=0 -> decrement.
- `db_tick` is 0 on every edge except the WAIT1->ONE transition.
- STABLE_CNT=1: `cnt` loads 0, so the transition occurs on the first wait-state cycle with `s2` still stable.

## Timing
- Reset (`reset`=0, asynchronous): `s1`=`s2`=0, state=ZERO, `cnt`=0, `db_level`=0, `db_tick`=0.
- Outputs hold these reset values while `reset` is low.
- The first update occurs on the first rising `clk` edge after `reset` returns high.
- Rise latency: `sw` sampled high at edge k and held stable.
  - `s2`=1 after edge k+1.
  - WAIT1 entered at edge k+2.
  - ONE entered at edge k+2+STABLE_CNT, so `db_level`=1 and `db_tick`=1 from that edge.
  - `db_tick` clears at edge k+3+STABLE_CNT.
  - Defaults: 12 edges.
- Fall latency is identical, STABLE_CNT+2 edges, with no strobe.
- Any opposite-level sample of `s2` during a wait state aborts the change. The next stable run restarts the count from STABLE_CNT-1; there is no partial credit.
- Reset asserted mid-wait: immediate return to ZERO with `db_level`=0, even if `db_level` was 1.
- Upstream change rate: at most one `db_tick` per 2·(STABLE_CNT+1) cycles by construction.

## Test plan
- Reset hold: `reset`=0 for 3 cycles with `sw` toggling -> `db_level`=0 and `db_tick`=0 throughout; release -> outputs still 0 until `sw` is stable.
- Clean rise (defaults): `sw` 0->1 sampled at edge 5 and held -> `db_level` rises at edge 17; `db_tick`=1 only between edges 17 and 18.
- Bounce on rise: `sw` pattern 1,1,1,0,1,1,... with the 0 sampled during WAIT1 -> FSM returns to ZERO, then re-qualifies; `db_level` rises 12 edges after the last 0->1 sample; exactly one `db_tick`.
- Clean fall and bounce on fall: from ONE, `sw`->0 with one 1-glitch at the 5th cycle -> `db_level` stays 1 until 12 edges after the final 1->0 sample; `db_tick` never asserts.
- Reset mid-operation: `db_level`=1, `sw`->0, `reset` pulsed low 3 edges into WAIT0 -> `db_level`=0 asynchronously; after release with `sw`=0, state remains ZERO and `db_tick` stays 0.
- Parameter corner: STABLE_CNT=1, CNT_W=1; single-cycle `sw` glitch -> no change; `sw` high for 3 cycles -> `db_level` rises 3 edges after the first high sample, with one `db_tick`.
